display_controller: RTL and testbench

- Laser-projector point engine.
- Captures point records from a received-packet byte buffer into a double-buffered point memory. Swaps banks on an end-of-frame sentinel.
- Replays the display bank continuously: X/Y go to two SPI DACs, R/G/B go out as 8-bit PWM.
- Sits between the network packet buffer and the galvo/laser driver board.

---
 rtl/display_controller.sv | 204 ++++++++++++++++++++
 tb/tb_display_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_controller.sv
// Laser-projector point engine: captures point tuples from the packet buffer into a
// double-buffered point RAM, replays the display bank to two SPI DACs plus RGB PWM.
// Optional macro DISPLAY_BLANK_EN: colour PWM only during DWELL (laser off while mirrors move).
module display_controller #(
  parameter int MAX_POINTS = 512,
  parameter int SPI_DIV    = 2,
  parameter int PT_OFFSET  = 15
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [31:0] frame_delay,
  input  logic [7:0]  pkt_buf_in [1518],
  output logic        x_sclk,
  output logic        x_mosi,
  output logic        x_cs,
  output logic        y_sclk,
  output logic        y_mosi,
  output logic        y_cs,
  output logic        r_pwm,
  output logic        g_pwm,
  output logic        b_pwm
);
  localparam int AW = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
  localparam int DW = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam logic [AW:0]   MAXP     = (AW+1)'(MAX_POINTS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SPI_DIV - 1);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pt_t;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DWELL} st_e;

  pt_t tup;
  assign tup = {pkt_buf_in[PT_OFFSET],   pkt_buf_in[PT_OFFSET+1], pkt_buf_in[PT_OFFSET+2],
                pkt_buf_in[PT_OFFSET+3], pkt_buf_in[PT_OFFSET+4], pkt_buf_in[PT_OFFSET+5],
                pkt_buf_in[PT_OFFSET+6]};

  // Both banks share one array; bank select is the address MSB.
  pt_t mem [2**(AW+1)];

  pt_t         prev_q;
  logic [AW:0] wr_ptr_q, disp_count_q;
  logic        fill_bank_q, swap_pend_q;
  logic        chg, sentinel, we, consume;

  st_e             st_q;
  logic [AW-1:0]   rd_idx_q, rd_idx_d;
  logic [15:0]     x_sh_q, y_sh_q;
  logic [7:0]      r_lvl_q, g_lvl_q, b_lvl_q;
  logic            cs_q, sclk_q;
  logic [DW-1:0]   div_q;
  logic [5:0]      ph_q;
  logic [31:0]     dwell_q, fd_eff;
  logic            dwell_done;

  assign chg      = (tup != prev_q);
  assign sentinel = (tup.x == 16'hFFFF);
  assign we       = chg && !sentinel && (wr_ptr_q < MAXP);

  always_ff @(posedge clock_in) begin
    if (we) mem[{fill_bank_q, wr_ptr_q[AW-1:0]}] <= tup;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      prev_q       <= '0;
      wr_ptr_q     <= '0;
      disp_count_q <= '0;
      fill_bank_q  <= 1'b0;
      swap_pend_q  <= 1'b0;
    end else begin
      if (consume) swap_pend_q <= 1'b0;
      if (chg) begin
        prev_q <= tup;
        if (sentinel) begin
          if (wr_ptr_q != '0) begin
            fill_bank_q  <= ~fill_bank_q;
            disp_count_q <= wr_ptr_q;
            wr_ptr_q     <= '0;
            swap_pend_q  <= 1'b1;  // wins over a same-cycle consume
          end
        end else if (wr_ptr_q < MAXP) begin
          wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
        end
      end
    end
  end

  assign fd_eff     = (frame_delay == 32'd0) ? 32'd1 : frame_delay;
  assign dwell_done = (dwell_q >= fd_eff - 32'd1);
  assign consume    = ((st_q == IDLE) && (disp_count_q != '0)) || ((st_q == DWELL) && dwell_done);

  // A pending swap restarts the new bank at index 0 once the current point is done.
  always_comb begin
    rd_idx_d = rd_idx_q + AW'(1);
    if (swap_pend_q || (({1'b0, rd_idx_q} + (AW+1)'(1)) >= disp_count_q)) rd_idx_d = '0;
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      st_q     <= IDLE;
      rd_idx_q <= '0;
      x_sh_q   <= '0;
      y_sh_q   <= '0;
      r_lvl_q  <= '0;
      g_lvl_q  <= '0;
      b_lvl_q  <= '0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      ph_q     <= '0;
      dwell_q  <= '0;
    end else begin
      case (st_q)
        IDLE: begin
          if (disp_count_q != '0) begin
            rd_idx_q <= '0;
            st_q     <= LOAD;
          end
        end
        LOAD: begin
          {x_sh_q, y_sh_q, r_lvl_q, g_lvl_q, b_lvl_q} <= mem[{~fill_bank_q, rd_idx_q}];
          cs_q  <= 1'b0;
          div_q <= '0;
          ph_q  <= '0;
          st_q  <= SEND;
        end
        SEND: begin
          // Phase 0 is cs setup; even phases end in a rising edge, odd in a falling
          // edge that also shifts the next bit out; phase 32 is cs hold.
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            ph_q  <= ph_q + 6'd1;
            if (ph_q == 6'd32) begin
              cs_q    <= 1'b1;
              x_sh_q  <= '0;
              y_sh_q  <= '0;
              dwell_q <= '0;
              st_q    <= DWELL;
            end else if (!ph_q[0]) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (ph_q != 6'd31) begin
                x_sh_q <= {x_sh_q[14:0], 1'b0};
                y_sh_q <= {y_sh_q[14:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + DW'(1);
          end
        end
        DWELL: begin
          if (dwell_done) begin
            rd_idx_q <= rd_idx_d;
            st_q     <= LOAD;
          end else begin
            dwell_q <= dwell_q + 32'd1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  logic [7:0] pwm_cnt_q;
  logic       r_pwm_q, g_pwm_q, b_pwm_q, pwm_en;

`ifdef DISPLAY_BLANK_EN
  assign pwm_en = (st_q == DWELL);
`else
  assign pwm_en = (st_q != IDLE);
`endif

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pwm_cnt_q <= '0;
      r_pwm_q   <= 1'b0;
      g_pwm_q   <= 1'b0;
      b_pwm_q   <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      r_pwm_q   <= pwm_en && (pwm_cnt_q < r_lvl_q);
      g_pwm_q   <= pwm_en && (pwm_cnt_q < g_lvl_q);
      b_pwm_q   <= pwm_en && (pwm_cnt_q < b_lvl_q);
    end
  end

  assign x_sclk = sclk_q;
  assign y_sclk = sclk_q;
  assign x_cs   = cs_q;
  assign y_cs   = cs_q;
  assign x_mosi = x_sh_q[15];
  assign y_mosi = y_sh_q[15];
  assign r_pwm  = r_pwm_q;
  assign g_pwm  = g_pwm_q;
  assign b_pwm  = b_pwm_q;

endmodule

// File: tb/tb_display_controller.sv
// Randomized bench for display_controller: queue-based point model, SPI frame decoder, PWM duty counter.
module tb_display_controller;
  localparam int MAXP = 512;
  localparam int DIV  = 2;
  localparam int OFF  = 15;
  localparam logic [55:0] SENT = 56'hFFFF_FFFF_FFFF_FF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fd;
  logic [7:0]  pkt [1518];
  logic x_sclk, x_mosi, x_cs, y_sclk, y_mosi, y_cs, r_pwm, g_pwm, b_pwm;

  always #5 clk = ~clk;

  display_controller #(.MAX_POINTS(MAXP), .SPI_DIV(DIV), .PT_OFFSET(OFF)) dut (
    .clock_in(clk), .reset_in(rst_n), .frame_delay(fd), .pkt_buf_in(pkt),
    .x_sclk(x_sclk), .x_mosi(x_mosi), .x_cs(x_cs),
    .y_sclk(y_sclk), .y_mosi(y_mosi), .y_cs(y_cs),
    .r_pwm(r_pwm), .g_pwm(g_pwm), .b_pwm(b_pwm)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI frame decoder
  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int xb, yb, start, rdly;
  } frame_t;

  frame_t fq[$];
  frame_t cur;
  int cyc = 0, viol = 0, csfalls = 0;
  logic pcs = 1'b1, psx = 1'b0, psy = 1'b0, pmx = 1'b0, pmy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (x_cs !== y_cs) viol++;
    if (pcs === 1'b1 && x_cs === 1'b0) begin
      cur.x = 0; cur.y = 0; cur.xb = 0; cur.yb = 0; cur.start = cyc; cur.rdly = -1;
      csfalls++;
    end
    if (x_cs === 1'b0) begin
      if (!psx && x_sclk) begin
        cur.x = {cur.x[14:0], x_mosi}; cur.xb++;
        if (cur.rdly < 0) cur.rdly = cyc - cur.start;
      end
      if (!psy && y_sclk) begin
        cur.y = {cur.y[14:0], y_mosi}; cur.yb++;
      end
      // data may only move on a falling SCLK edge while selected
      if (pcs === 1'b0 && ((x_mosi !== pmx) || (y_mosi !== pmy)) && !(psx && !x_sclk)) viol++;
    end
    if (pcs === 1'b0 && x_cs === 1'b1) fq.push_back(cur);
    pcs = x_cs; psx = x_sclk; psy = y_sclk; pmx = x_mosi; pmy = y_mosi;
  end

  // Reference model: points queue up in the fill list; a fresh sentinel publishes it.
  logic [55:0] m_prev;
  logic [55:0] m_fill[$];
  logic [55:0] m_disp[$];
  int m_idx = 0;

  task automatic model_put(input logic [55:0] t);
    if (t == m_prev) return;
    m_prev = t;
    if (t[55:40] == 16'hFFFF) begin
      if (m_fill.size() > 0) begin
        m_disp = m_fill;
        m_fill.delete();
        m_idx = 0;
      end
    end else if (m_fill.size() < MAXP) begin
      m_fill.push_back(t);
    end
  endtask

  task automatic put(input logic [55:0] t);
    @(negedge clk);
    for (int i = 0; i < 7; i++) pkt[OFF+i] = t[55-8*i -: 8];
    model_put(t);
    @(negedge clk);
  endtask

  function automatic logic [55:0] rnd_pt(input logic [55:0] prev);
    logic [55:0] t;
    do begin
      t[55:32] = 24'($urandom);
      t[31:0]  = $urandom;
    end while (t == prev || t[55:40] == 16'hFFFF);
    return t;
  endfunction

  task automatic get_frame(output frame_t f, input int budget);
    int n = 0;
    while (fq.size() == 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (fq.size() == 0) begin
      chk("frame_timeout", fq.size(), 1);
      f.x = 0; f.y = 0; f.xb = 0; f.yb = 0; f.start = 0; f.rdly = 0;
    end else begin
      f = fq.pop_front();
    end
  endtask

  task automatic check_next(input string tag, input int budget, output frame_t f);
    logic [55:0] p;
    get_frame(f, budget);
    p = m_disp[m_idx];
    chk({tag, "_x"}, f.x, p[55:40]);
    chk({tag, "_y"}, f.y, p[39:24]);
    chk({tag, "_bits"}, {f.xb[15:0], f.yb[15:0]}, {16'd16, 16'd16});
    m_idx = (m_idx + 1) % m_disp.size();
  endtask

  task automatic run_frames(input string tag, input int n);
    frame_t f;
    for (int i = 0; i < n; i++) check_next(tag, 3000, f);
  endtask

  // drain old frames, then align to the start of a DWELL before sending the sentinel
  task automatic sync_swap(input string tag);
    frame_t f;
    while (fq.size() > 0) check_next({tag, "_old"}, 10, f);
    check_next({tag, "_old"}, 3000, f);
    put(SENT);
  endtask

  task automatic frame_and_duty(input string tag);
    frame_t f;
    logic [55:0] p;
    int rc = 0, gc = 0, bc = 0;
    p = m_disp[m_idx];
    check_next(tag, 3000, f);
    chk({tag, "_cs_setup"}, f.rdly, DIV);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      rc += int'(r_pwm); gc += int'(g_pwm); bc += int'(b_pwm);
    end
    chk({tag, "_duty_r"}, rc, p[23:16]);
    chk({tag, "_duty_g"}, gc, p[15:8]);
    chk({tag, "_duty_b"}, bc, p[7:0]);
  endtask

  task automatic period(input logic [31:0] d, output int p);
    frame_t f0, f1, f2;
    while (fq.size() > 0) check_next("per_old", 10, f0);
    fd = d;
    check_next("per", int'(d) + 2000, f0);
    check_next("per", int'(d) + 2000, f1);
    check_next("per", int'(d) + 2000, f2);
    p = f2.start - f1.start;
  endtask

  initial begin
    int n, hi, p0, p1, p3, snap;
    logic [55:0] t;
    rst_n = 1'b1;
    fd = 32'd300;
    m_prev = '0;
    for (int i = 0; i < 1518; i++) pkt[i] = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs", {x_cs, y_cs}, 2'b11);
    chk("rst_sclk", {x_sclk, y_sclk}, 2'b00);
    chk("rst_mosi", {x_mosi, y_mosi}, 2'b00);
    chk("rst_pwm", {r_pwm, g_pwm, b_pwm}, 3'b000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // all-zero tuple after reset: no display
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      hi += int'(r_pwm | g_pwm | b_pwm);
    end
    chk("idle_cs_falls", csfalls, 0);
    chk("idle_pwm", hi, 0);
    chk("idle_cs", x_cs, 1'b1);

    // six points, sentinel, first frame and duty
    for (int v = 1; v <= 6; v++) begin
      t = {7{8'(v)}};
      put(t);
    end
    put(SENT);
    frame_and_duty("first");
    run_frames("seq6", 7);

    // held sentinel: no second swap, sequence continues
    repeat (3) put(SENT);
    run_frames("rep_sent", 7);

    // second list FE..FA, swap lands while a point is in flight
    for (int v = 8'hFE; v >= 8'hFA; v--) begin
      t = {7{8'(v)}};
      put(t);
    end
    sync_swap("swap2");
    frame_and_duty("swap2_first");
    run_frames("seq5", 6);

    // random lists
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(2, 10);
      for (int i = 0; i < n; i++) put(rnd_pt(m_prev));
      sync_swap("rnd_swap");
      frame_and_duty("rnd_first");
      run_frames("rnd_seq", n + 1);
    end

    // point period vs frame_delay
    period(32'd1, p1);
    chk("period_fd1_range", (p1 >= 1 + 32*DIV) && (p1 <= 3 + 34*DIV), 1);
    period(32'd0, p0);
    chk("period_fd0_as_fd1", p0, p1);
    period(32'd3000, p3);
    chk("period_fd3000_delta", p3 - p1, 2999);

    // overflow: MAXP+3 points, extras dropped, display wraps at MAXP
    fd = 32'd40;
    for (int i = 0; i < MAXP + 3; i++) put(rnd_pt(m_prev));
    sync_swap("max_swap");
    fd = 32'd1;
    run_frames("max_seq", MAXP + 1);

    // reset during an SPI frame
    n = 0;
    while (x_cs !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_cs_low_seen", x_cs, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", {x_cs, y_cs}, 2'b11);
    chk("mid_rst_sclk", {x_sclk, y_sclk}, 2'b00);
    chk("mid_rst_pwm", {r_pwm, g_pwm, b_pwm}, 3'b000);
    m_prev = '0;
    m_fill.delete();
    m_disp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fq.delete();
    snap = csfalls;
    repeat (300) @(negedge clk);
    chk("post_rst_idle", csfalls - snap, 0);

    chk("spi_protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
